// File: rtl/bool_tt_eval_seq.sv
// Programmable N-input Boolean function held as a 2**N_IN-entry truth table.
// Valid/ready evaluation path plus an exhaustive sweep that reports minterm count and constant flags.
//
// state | meaning
// IDLE  | waiting for sweep_start; eval path open
// SWEEP | walking idx over every minterm, accumulating ones (TT_W cycles)
// DONE  | one-cycle completion: publish count and constant flags
module bool_tt_eval_seq #(
   parameter int N_IN = 3,
   parameter int TT_W = 1 << N_IN,
   parameter logic [TT_W-1:0] RESET_TT = 8'h5A
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tt_load,
   input  logic [TT_W-1:0]   tt_in,
   output logic [TT_W-1:0]   tt_q,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN-1:0]   in_vars,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_f,
   input  logic              sweep_start,
   output logic              sweep_busy,
   output logic              sweep_done,
   output logic [N_IN:0]     ones_cnt,
   output logic              is_const0,
   output logic              is_const1
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(TT_W - 1);
   localparam logic [N_IN:0] FULL_CNT = (N_IN+1)'(TT_W);
   localparam logic [N_IN:0] CNT_ONE  = (N_IN+1)'(1);

   logic [1:0]    state_q;
   logic [1:0]    state_d;
   logic [N_IN:0] idx_q;
   logic [N_IN:0] acc_q;
   logic          tt_bit;
   logic          accept;

   assign sweep_busy = (state_q == ST_SWEEP);
   assign sweep_done = (state_q == ST_DONE);
   assign in_ready   = !sweep_busy && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign tt_bit     = tt_q[idx_q[N_IN-1:0]];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (sweep_start) state_d = ST_SWEEP;
         ST_SWEEP: if (idx_q == LAST_IDX) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         ones_cnt  <= '0;
         is_const0 <= 1'b0;
         is_const1 <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (sweep_start) begin
                  idx_q <= '0;
                  acc_q <= '0;
               end
            end
            ST_SWEEP: begin
               acc_q <= acc_q + {{N_IN{1'b0}}, tt_bit};
               idx_q <= idx_q + CNT_ONE;
            end
            ST_DONE: begin
               ones_cnt  <= acc_q;
               is_const0 <= (acc_q == '0);
               is_const1 <= (acc_q == FULL_CNT);
            end
            default: ;
         endcase
      end
   end

   // A load is blocked only while the sweep is reading the table.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt_q <= RESET_TT;
      end else if (tt_load && !sweep_busy) begin
         tt_q <= tt_in;
      end
   end

   // Eval reads tt_q before any same-edge load lands, so it sees the old table.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_f     <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_f     <= tt_q[in_vars];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bool_tt_eval_seq.sv
// Self-checking bench for bool_tt_eval_seq: directed scenarios plus a randomized
// eval/load run against a truth-table reference model.
module tb_bool_tt_eval_seq;

   localparam int TT_W = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tt_load = 1'b0;
   logic [7:0] tt_in = 8'h00;
   logic [7:0] tt_q;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_vars = 3'b000;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_f;
   logic       sweep_start = 1'b0;
   logic       sweep_busy;
   logic       sweep_done;
   logic [3:0] ones_cnt;
   logic       is_const0;
   logic       is_const1;

   int checks = 0;
   int errors = 0;
   logic [7:0] model_tt = 8'h5A;

   always #5 clk = ~clk;

   bool_tt_eval_seq #(.N_IN(3), .TT_W(8), .RESET_TT(8'h5A)) dut (
      .clk(clk), .rst_n(rst_n),
      .tt_load(tt_load), .tt_in(tt_in), .tt_q(tt_q),
      .in_valid(in_valid), .in_ready(in_ready), .in_vars(in_vars),
      .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
      .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
      .ones_cnt(ones_cnt), .is_const0(is_const0), .is_const1(is_const1)
   );

   function automatic int count_ones(input logic [7:0] t);
      int n = 0;
      for (int b = 0; b < 8; b++) if (t[b]) n++;
      return n;
   endfunction

   task automatic idle_inputs();
      tt_load = 1'b0; in_valid = 1'b0; sweep_start = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      checks++; if (tt_q !== 8'h5A) begin errors++; $display("FAIL reset_tt got %h exp 5a", tt_q); end
      checks++; if ({out_valid, out_f, sweep_busy, sweep_done, is_const0, is_const1} !== 6'b0) begin
         errors++; $display("FAIL reset_flags got %b exp 000000", {out_valid, out_f, sweep_busy, sweep_done, is_const0, is_const1});
      end
      checks++; if (ones_cnt !== 4'd0) begin errors++; $display("FAIL reset_ones got %0d exp 0", ones_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      rst_n = 1'b1;
      model_tt = 8'h5A;
      @(negedge clk);
   endtask

   task automatic test_eval_basic();
      logic [2:0] vecs [4];
      logic       exp_f [4];
      vecs  = '{3'b000, 3'b001, 3'b100, 3'b111};
      exp_f = '{1'b0, 1'b1, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_vars = vecs[i];
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || out_f !== exp_f[i]) begin
            errors++; $display("FAIL t1_eval vec=%b got valid=%b f=%b exp valid=1 f=%b", vecs[i], out_valid, out_f, exp_f[i]);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_drain got valid=%b exp 0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; in_vars = 3'b001;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_f !== 1'b1) begin
         errors++; $display("FAIL t2_first got valid=%b f=%b exp 1 1", out_valid, out_f);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t2_ready got %b exp 0", in_ready); end
      in_vars = 3'b010;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_f !== 1'b1) begin
         errors++; $display("FAIL t2_hold got valid=%b f=%b exp 1 1", out_valid, out_f);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_f !== 1'b0) begin
         errors++; $display("FAIL t2_second got valid=%b f=%b exp 1 0", out_valid, out_f);
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_nodup got valid=%b exp 0", out_valid); end
   endtask

   // Starts a sweep (caller may pre-set tt_load/tt_in for a same-cycle load) and checks the result.
   task automatic run_sweep(input logic [7:0] exp_tt);
      int busy_cycles = 0;
      bit seen = 1'b0;
      sweep_start = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0; tt_load = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (sweep_done) seen = 1'b1;
         else begin
            if (sweep_busy) busy_cycles++;
            @(negedge clk);
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL sweep_done_seen got 0 exp 1"); end
      checks++; if (busy_cycles != TT_W) begin errors++; $display("FAIL sweep_busy_len got %0d exp %0d", busy_cycles, TT_W); end
      @(negedge clk);
      checks++; if (sweep_done !== 1'b0 || sweep_busy !== 1'b0) begin
         errors++; $display("FAIL sweep_idle got done=%b busy=%b exp 0 0", sweep_done, sweep_busy);
      end
      checks++; if (ones_cnt !== 4'(count_ones(exp_tt))) begin
         errors++; $display("FAIL sweep_ones tt=%h got %0d exp %0d", exp_tt, ones_cnt, count_ones(exp_tt));
      end
      checks++; if (is_const0 !== (exp_tt == 8'h00) || is_const1 !== (exp_tt == 8'hFF)) begin
         errors++; $display("FAIL sweep_const tt=%h got c0=%b c1=%b exp c0=%b c1=%b", exp_tt, is_const0, is_const1,
                            exp_tt == 8'h00, exp_tt == 8'hFF);
      end
   endtask

   task automatic load_table(input logic [7:0] t);
      tt_load = 1'b1; tt_in = t;
      @(negedge clk);
      tt_load = 1'b0;
      model_tt = t;
      checks++; if (tt_q !== t) begin errors++; $display("FAIL load_tt got %h exp %h", tt_q, t); end
   endtask

   task automatic test_sweep();
      run_sweep(model_tt);
   endtask

   task automatic test_const();
      logic [7:0] r;
      load_table(8'hFF);
      run_sweep(8'hFF);
      load_table(8'h00);
      run_sweep(8'h00);
      r = 8'($urandom);
      tt_load = 1'b1; tt_in = r; model_tt = r;
      run_sweep(r);
      load_table(8'h5A);
   endtask

   task automatic test_load_during_sweep();
      bit seen = 1'b0;
      sweep_start = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0;
      @(negedge clk);
      tt_load = 1'b1; tt_in = 8'h00;
      @(negedge clk);
      tt_load = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (sweep_done) seen = 1'b1;
         else @(negedge clk);
      end
      checks++; if (!seen) begin errors++; $display("FAIL t5_done got 0 exp 1"); end
      @(negedge clk);
      checks++; if (tt_q !== 8'h5A) begin errors++; $display("FAIL t5_tt_kept got %h exp 5a", tt_q); end
      checks++; if (ones_cnt !== 4'd4) begin errors++; $display("FAIL t5_ones got %0d exp 4", ones_cnt); end
      out_ready = 1'b1;
      tt_load = 1'b1; tt_in = 8'h00; in_valid = 1'b1; in_vars = 3'b111;
      @(negedge clk);
      checks++; if (out_f !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL t5_old_tt_111 got valid=%b f=%b exp 1 0", out_valid, out_f);
      end
      tt_in = 8'hFF; in_vars = 3'b001;
      @(negedge clk);
      checks++; if (out_f !== 1'b0) begin errors++; $display("FAIL t5_old_tt_001 got %b exp 0", out_f); end
      checks++; if (tt_q !== 8'hFF) begin errors++; $display("FAIL t5_new_tt got %h exp ff", tt_q); end
      tt_load = 1'b0;
      @(negedge clk);
      checks++; if (out_f !== 1'b1) begin errors++; $display("FAIL t5_new_eval got %b exp 1", out_f); end
      in_valid = 1'b0;
      model_tt = 8'hFF;
      load_table(8'h5A);
   endtask

   task automatic test_reset_mid();
      bit done_seen = 1'b0;
      load_table(8'hFF);
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_vars = 3'b001; sweep_start = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; sweep_start = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_f !== 1'b1 || sweep_busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL t6_concurrent got valid=%b f=%b busy=%b ready=%b exp 1 1 1 0", out_valid, out_f, sweep_busy, in_ready);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (tt_q !== 8'h5A) begin errors++; $display("FAIL t6_tt got %h exp 5a", tt_q); end
      checks++; if ({out_valid, sweep_busy, sweep_done, is_const0, is_const1} !== 5'b0 || ones_cnt !== 4'd0) begin
         errors++; $display("FAIL t6_reset got flags=%b ones=%0d exp 00000 0", {out_valid, sweep_busy, sweep_done, is_const0, is_const1}, ones_cnt);
      end
      model_tt = 8'h5A;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (sweep_done) done_seen = 1'b1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (sweep_done) done_seen = 1'b1;
      end
      checks++; if (done_seen) begin errors++; $display("FAIL t6_no_done got 1 exp 0"); end
      run_sweep(8'h5A);
   endtask

   task automatic test_random();
      logic mv = 1'b0;
      logic mf = 1'b0;
      logic exp_ready;
      idle_inputs();
      @(negedge clk);
      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom);
         in_vars   = 3'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tt_load   = ($urandom_range(0, 7) == 0);
         tt_in     = 8'($urandom);
         exp_ready = !mv || out_ready;
         #1;
         checks++; if (in_ready !== exp_ready) begin
            errors++; $display("FAIL rnd_ready cycle=%0d got %b exp %b", c, in_ready, exp_ready);
         end
         if (in_valid && exp_ready) begin
            mf = model_tt[in_vars];
            mv = 1'b1;
         end else if (out_ready) begin
            mv = 1'b0;
         end
         if (tt_load) model_tt = tt_in;
         @(negedge clk);
         checks++; if (out_valid !== mv || (mv && out_f !== mf)) begin
            errors++; $display("FAIL rnd_out cycle=%0d got valid=%b f=%b exp valid=%b f=%b", c, out_valid, out_f, mv, mf);
         end
         checks++; if (tt_q !== model_tt) begin
            errors++; $display("FAIL rnd_tt cycle=%0d got %h exp %h", c, tt_q, model_tt);
         end
      end
      idle_inputs();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_eval_basic();
      test_backpressure();
      test_sweep();
      test_const();
      test_load_during_sweep();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
